// File: rtl/adc_signal_conditioner_if.sv
// Sample-side bus of the ADC signal conditioner: raw ADC input plus conditioned
// outputs and window statistics. master = sample source / consumer, slave = conditioner.
// Signals: sample_en/adc_data in; signal_dc_removed/signal_valid, vpp/dc_offset/dc_mean,
//          sig_present, stats_update out.
interface adc_signal_conditioner_if;
  logic       sample_en;
  logic [7:0] adc_data;
  logic [7:0] signal_dc_removed;
  logic       signal_valid;
  logic [7:0] vpp;
  logic [7:0] dc_offset;
  logic [7:0] dc_mean;
  logic       sig_present;
  logic       stats_update;

  modport master (
    output sample_en, adc_data,
    input  signal_dc_removed, signal_valid, vpp, dc_offset, dc_mean,
           sig_present, stats_update
  );

  modport slave (
    input  sample_en, adc_data,
    output signal_dc_removed, signal_valid, vpp, dc_offset, dc_mean,
           sig_present, stats_update
  );
endinterface

// File: rtl/adc_signal_conditioner.sv
// Windowed min/max/mean of unsigned ADC samples; re-centres each sample on the last offset.
// Latency: 1 cycle sample->signal_dc_removed, 1 cycle window-end sample->stats.
// No backpressure: sample_en qualifies each input; idle cycles hold all outputs.
// Ports: sample_clk, rst_n (async active-low), bus (slave modport of adc_signal_conditioner_if).
module adc_signal_conditioner #(
  parameter int WINDOW      = 256,
  parameter int LOG2_WINDOW = 8,
  parameter int MIN_VPP     = 8
) (
  input  logic                      sample_clk,
  input  logic                      rst_n,
  adc_signal_conditioner_if.slave   bus
);

  typedef enum logic {WARMUP = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [LOG2_WINDOW-1:0] LAST_IDX = LOG2_WINDOW'(WINDOW - 1);
  localparam int SUM_W = LOG2_WINDOW + 8;

  state_t                 state_q, state_d;
  logic [LOG2_WINDOW-1:0] win_cnt_q, win_cnt_d;
  logic [7:0]             run_min_q, run_min_d;
  logic [7:0]             run_max_q, run_max_d;
  logic [SUM_W-1:0]       run_sum_q, run_sum_d;
  logic [7:0]             vpp_q, vpp_d;
  logic [7:0]             dc_offset_q, dc_offset_d;
  logic [7:0]             dc_mean_q, dc_mean_d;
  logic                   sig_present_q, sig_present_d;
  logic                   stats_update_q, stats_update_d;
  logic                   signal_valid_q, signal_valid_d;
  logic [7:0]             signal_out_q, signal_out_d;

  logic [7:0]             min_p, max_p;
  logic [SUM_W-1:0]       sum_p;
  logic [8:0]             mid_sum;
  logic signed [8:0]      diff;
  logic [7:0]             sat;

  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= WARMUP;
      win_cnt_q      <= '0;
      run_min_q      <= 8'hFF;
      run_max_q      <= 8'h00;
      run_sum_q      <= '0;
      vpp_q          <= 8'h00;
      dc_offset_q    <= 8'h00;
      dc_mean_q      <= 8'h00;
      sig_present_q  <= 1'b0;
      stats_update_q <= 1'b0;
      signal_valid_q <= 1'b0;
      signal_out_q   <= 8'h00;
    end else begin
      state_q        <= state_d;
      win_cnt_q      <= win_cnt_d;
      run_min_q      <= run_min_d;
      run_max_q      <= run_max_d;
      run_sum_q      <= run_sum_d;
      vpp_q          <= vpp_d;
      dc_offset_q    <= dc_offset_d;
      dc_mean_q      <= dc_mean_d;
      sig_present_q  <= sig_present_d;
      stats_update_q <= stats_update_d;
      signal_valid_q <= signal_valid_d;
      signal_out_q   <= signal_out_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    win_cnt_d      = win_cnt_q;
    run_min_d      = run_min_q;
    run_max_d      = run_max_q;
    run_sum_d      = run_sum_q;
    vpp_d          = vpp_q;
    dc_offset_d    = dc_offset_q;
    dc_mean_d      = dc_mean_q;
    sig_present_d  = sig_present_q;
    stats_update_d = 1'b0;
    signal_valid_d = 1'b0;
    signal_out_d   = signal_out_q;

    // Window statistics including the sample presented this cycle.
    min_p   = (bus.adc_data < run_min_q) ? bus.adc_data : run_min_q;
    max_p   = (bus.adc_data > run_max_q) ? bus.adc_data : run_max_q;
    sum_p   = run_sum_q + SUM_W'(bus.adc_data);
    mid_sum = {1'b0, max_p} + {1'b0, min_p};

    // Re-centre against the offset currently held; 9 bits covers -255..255.
    diff = $signed({1'b0, bus.adc_data}) - $signed({1'b0, dc_offset_q});
    if (diff > $signed(9'd127))
      sat = 8'h7F;
    else if (diff < -9'sd128)
      sat = 8'h80;
    else
      sat = diff[7:0];

    if (bus.sample_en) begin
      win_cnt_d = win_cnt_q + 1'b1;
      run_min_d = min_p;
      run_max_d = max_p;
      run_sum_d = sum_p;

      if (state_q == TRACK) begin
        signal_valid_d = 1'b1;
        // Without a meaningful swing, emit zeros so DC input carries no energy downstream.
        signal_out_d   = sig_present_q ? sat : 8'h00;
      end

      if (win_cnt_q == LAST_IDX) begin
        vpp_d          = max_p - min_p;
        dc_offset_d    = 8'(mid_sum >> 1);
        dc_mean_d      = 8'(sum_p >> LOG2_WINDOW);
        sig_present_d  = ((max_p - min_p) >= 8'(MIN_VPP));
        stats_update_d = 1'b1;
        run_min_d      = 8'hFF;
        run_max_d      = 8'h00;
        run_sum_d      = '0;
        win_cnt_d      = '0;
        state_d        = TRACK;
      end
    end
  end

  assign bus.signal_dc_removed = signal_out_q;
  assign bus.signal_valid      = signal_valid_q;
  assign bus.vpp               = vpp_q;
  assign bus.dc_offset         = dc_offset_q;
  assign bus.dc_mean           = dc_mean_q;
  assign bus.sig_present       = sig_present_q;
  assign bus.stats_update      = stats_update_q;

endmodule

// File: doc/adc_signal_conditioner.md
Name: adc_signal_conditioner

Overview:
- Sits directly upstream of the waveform identifier and feeds it the three inputs it needs: `signal_dc_removed`, `vpp` and `dc_offset`.
- Takes unsigned 8-bit ADC samples and measures min, max and mean over fixed windows of WINDOW samples.
- At each window boundary it latches peak-to-peak, midpoint offset and mean.
- Every sample is re-centred against the last latched offset and saturated to signed 8-bit.

Parameters:
- WINDOW, 256, samples per measurement window; must be a power of 2.
- LOG2_WINDOW, 8, log2(WINDOW).
- MIN_VPP, 8, vpp threshold (LSB) at or above which a signal is declared present.

Ports:
- sample_clk  in  1  sample clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sample_en  in  1  adc_data is valid this cycle.
- adc_data  in  8  unsigned ADC sample.
- signal_dc_removed  out  8  signed sample minus dc_offset, saturated.
- signal_valid  out  1  signal_dc_removed updated this cycle.
- vpp  out  8  unsigned max−min of the last completed window.
- dc_offset  out  8  unsigned floor((max+min)/2) of the last completed window.
- dc_mean  out  8  unsigned floor(sum/WINDOW) of the last completed window.
- sig_present  out  1  vpp >= MIN_VPP.
- stats_update  out  1  one-cycle pulse when the window statistics are relatched.

Behaviour:
- Reset (async assert, sync release): every output is 0. State=WARMUP, win_cnt=0, run_min=255, run_max=0, run_sum=0.
- Advance rule: internal state changes only on cycles with sample_en=1. With sample_en=0 all outputs hold, except that signal_valid and stats_update are 0.
- Per accepted sample:
  - run_min=min(run_min,adc_data); run_max=max(run_max,adc_data).
  - run_sum += adc_data; run_sum is LOG2_WINDOW+8 bits and cannot overflow.
  - win_cnt increments.
- Window end is an accepted sample with win_cnt==WINDOW−1. On the next edge:
  - vpp=max'−min'; dc_offset=(max'+min')>>1 using a 9-bit sum; dc_mean=sum'>>LOG2_WINDOW. The primed values include the current sample.
  - run_min=255, run_max=0, run_sum=0, win_cnt=0; wraps cleanly into the next window.
  - stats_update=1 for exactly one cycle.
  - sig_present is registered from the new vpp in the same cycle.
  - State WARMUP→TRACK, or TRACK→TRACK.
- States:
  - WARMUP: no statistics exist yet. Accepted samples do not produce output: signal_dc_removed=0, signal_valid=0.
  - TRACK: each accepted sample gives, on the next edge, signal_valid=1 and signal_dc_removed=sat8({0,adc_data}−{0,dc_offset}). The subtraction is 9-bit signed; sat8 clamps to [−128,127].
- Offset used for output: always the dc_offset register value in the cycle the sample is accepted.
  - On the window-end sample, output uses the old offset. The new offset applies from the next accepted sample.
- Signal gating: in TRACK with sig_present=0, signal_valid still pulses but signal_dc_removed=0. This keeps downstream energy accumulation at 0 on DC-only input.
- Latency:
  - signal_dc_removed/signal_valid: 1 cycle after the accepted sample.
  - Window stats: 1 cycle after the window-end sample.
- Reset mid-window: the partial window is discarded, outputs return to 0 and the block re-enters WARMUP. A full WINDOW of samples is needed before the first signal_valid.
- stats_update and signal_valid can assert in the same cycle (window-end sample in TRACK).

Test Plan:
- Reset, then 255 accepted samples → all outputs 0, no signal_valid, no stats_update. 256th sample → stats_update pulse one cycle later.
- Constant adc_data=100 for 2 windows → vpp=0, dc_offset=100, dc_mean=100, sig_present=0. In window 2 signal_valid pulses with signal_dc_removed=0.
- Square 50/200 (equal halves) for 2 windows → vpp=150, dc_offset=125, dc_mean=125, sig_present=1. Window 2 outputs −75 / +75.
- Square 0/255 → vpp=255, dc_offset=127. Next window outputs −127 and +127 (255−127=128 saturated to 127).
- Apply the same square with sample_en toggled every other cycle → identical stats and output sequence. signal_valid=0 and outputs hold on idle cycles.
- Window boundary: window 1 = 100 constant, window 2 = 50/200 square, check the first sample of window 3. The window-2 end-sample output uses dc_offset=100; the next sample uses 125.
- Reset mid-window 2 → outputs 0 immediately, WARMUP re-entered, no signal_valid for the next 256 samples.
